// File: rtl/instr_fetch_if.sv
// Bus bundle between instr_fetch, the combinational program ROM and the execute stage.
// master: fetch sequencer side; slave: ROM/execute side.
interface instr_fetch_if;
   logic [7:0] rom_address;
   logic [7:0] rom_dataout;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr_opcode;
   logic [7:0] instr_imm;
   logic       instr_has_imm;
   logic [7:0] instr_pc;
   logic       jump_valid;
   logic [7:0] jump_target;

   modport master (
      output rom_address,
      output instr_valid,
      output instr_opcode,
      output instr_imm,
      output instr_has_imm,
      output instr_pc,
      input  rom_dataout,
      input  instr_ready,
      input  jump_valid,
      input  jump_target
   );

   modport slave (
      input  rom_address,
      input  instr_valid,
      input  instr_opcode,
      input  instr_imm,
      input  instr_has_imm,
      input  instr_pc,
      output rom_dataout,
      output instr_ready,
      output jump_valid,
      output jump_target
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: walks the PC over a combinational ROM, assembles 1/2-byte
// instructions and hands them to execute. Define INSTR_FETCH_HALT_EN to make opcode 8'h00 HALT.
module instr_fetch #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic          clk,
   input  logic          rst_n,
   instr_fetch_if.master bus
);

`ifdef INSTR_FETCH_HALT_EN
   typedef enum logic [1:0] {StFetchOp, StFetchImm, StHold, StHalted} state_e;
`else
   typedef enum logic [1:0] {StFetchOp, StFetchImm, StHold} state_e;
`endif

   state_e     r_state;
   state_e     w_state_next;
   logic [7:0] r_pc;
   logic [7:0] w_pc_next;
   logic [7:0] r_opcode;
   logic [7:0] w_opcode_next;
   logic [7:0] r_imm;
   logic [7:0] w_imm_next;
   logic       r_has_imm;
   logic       w_has_imm_next;
   logic [7:0] r_instr_pc;
   logic [7:0] w_instr_pc_next;
   logic       w_valid;
   logic       w_handshake;

   assign w_valid     = (r_state == StHold);
   assign w_handshake = w_valid & bus.instr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StFetchOp;
         r_pc       <= RESET_PC;
         r_opcode   <= 8'h00;
         r_imm      <= 8'h00;
         r_has_imm  <= 1'b0;
         r_instr_pc <= 8'h00;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_opcode   <= w_opcode_next;
         r_imm      <= w_imm_next;
         r_has_imm  <= w_has_imm_next;
         r_instr_pc <= w_instr_pc_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_pc_next       = r_pc;
      w_opcode_next   = r_opcode;
      w_imm_next      = r_imm;
      w_has_imm_next  = r_has_imm;
      w_instr_pc_next = r_instr_pc;

      case (r_state)
         StFetchOp: begin
            w_opcode_next   = bus.rom_dataout;
            w_instr_pc_next = r_pc;
            w_pc_next       = r_pc + 8'd1;
            w_imm_next      = 8'h00;
            w_has_imm_next  = 1'b0;
            w_state_next    = bus.rom_dataout[7] ? StFetchImm : StHold;
         end
         StFetchImm: begin
            w_imm_next     = bus.rom_dataout;
            w_has_imm_next = 1'b1;
            w_pc_next      = r_pc + 8'd1;
            w_state_next   = StHold;
         end
         StHold: begin
            if (w_handshake) begin
               w_state_next = StFetchOp;
`ifdef INSTR_FETCH_HALT_EN
               if (r_opcode == 8'h00) w_state_next = StHalted;
`endif
            end
         end
         default: begin
            w_state_next = r_state;
         end
      endcase

      // A redirect beats every transition; a coinciding handshake has already consumed HOLD.
      if (bus.jump_valid) begin
         w_pc_next    = bus.jump_target;
         w_state_next = StFetchOp;
      end
   end

   assign bus.rom_address   = r_pc;
   assign bus.instr_valid   = w_valid;
   assign bus.instr_opcode  = r_opcode;
   assign bus.instr_imm     = r_imm;
   assign bus.instr_has_imm = r_has_imm;
   assign bus.instr_pc      = r_instr_pc;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer that sits directly upstream of the program ROM: it drives the ROM address, captures the returned byte, and assembles one- and two-byte instructions. Complete instructions go to the execute stage over a valid/ready handshake. It owns the program counter and accepts jump redirects from execute. The ROM is purely combinational, so data for the driven address is valid in the same cycle.

## Interface
Parameters:
- RESET_PC, 8'h00, program counter value loaded on reset.

Ports:
- clk, input, 1, sole clock; all state updates on its rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- rom_address, output, 8, ROM address; equals the current PC.
- rom_dataout, input, 8, ROM byte at rom_address, same cycle.
- instr_valid, output, 1, assembled instruction is presented.
- instr_ready, input, 1, execute stage accepts the instruction.
- instr_opcode, output, 8, first instruction byte.
- instr_imm, output, 8, immediate byte; 8'h00 when instr_has_imm=0.
- instr_has_imm, output, 1, instruction is two bytes.
- instr_pc, output, 8, address of the opcode byte.
- jump_valid, input, 1, redirect request from execute.
- jump_target, input, 8, new PC for the redirect.

## Operation
- Encoding: opcode bit 7 = 1 means exactly one immediate byte follows. Bit 7 = 0 means a one-byte instruction.
- State machine: FETCH_OP, FETCH_IMM, HOLD (plus HALTED, see Configuration).
- FETCH_OP: latch rom_dataout into instr_opcode and the PC into instr_pc, then increment the PC.
  - Next state is FETCH_IMM if bit 7 = 1.
  - Otherwise next state is HOLD, with instr_imm cleared to 0 and instr_has_imm cleared to 0.
- FETCH_IMM: latch rom_dataout into instr_imm, set instr_has_imm, increment the PC, next state HOLD.
- HOLD: instr_valid = 1. All instr_* outputs stay stable until the handshake (instr_valid & instr_ready).
  - On the handshake, next state is FETCH_OP.
  - No fetch occurs while in HOLD; the PC is frozen.
- PC arithmetic: 8-bit, modulo 256. 8'hFF + 1 wraps to 8'h00, with no flag. An immediate fetched across the wrap comes from 8'h00.
- Jump: jump_valid has priority over every transition.
  - The PC loads jump_target and the next state is FETCH_OP.
  - Any partially assembled or held instruction is discarded, so instr_valid is 0 in the next cycle.
  - Exception: if the handshake and jump_valid coincide, the held instruction counts as accepted. This is consumed, not discarded.
- Reset mid-operation: asynchronous return to reset values regardless of state. Any in-flight instruction is lost.
- Reset values:
  - state FETCH_OP, PC = RESET_PC, rom_address = RESET_PC.
  - instr_valid = 0, instr_opcode = 0, instr_imm = 0, instr_has_imm = 0, instr_pc = 0.

## Timing
- instr_valid is a registered output, derived from the state only, with no combinational path from instr_ready.
- One-byte instruction: FETCH_OP in cycle N, instr_valid high from cycle N+1.
- Two-byte instruction: FETCH_OP in N, FETCH_IMM in N+1, instr_valid high from N+2.
- Throughput with instr_ready held high: one-byte instructions every 2 cycles, two-byte instructions every 3 cycles.
- Jump asserted in cycle N: rom_address = jump_target in cycle N+1, and the first redirected instruction is valid at N+2 at the earliest.
- jump_valid is sampled every cycle, in every state.

## Configuration
- Macro: INSTR_FETCH_HALT_EN.
- Defined: opcode 8'h00 is HALT.
  - It is delivered normally through HOLD.
  - On its handshake the FSM enters HALTED instead of FETCH_OP.
  - HALTED: no fetch, PC frozen at the address after HALT, instr_valid = 0.
  - Only jump_valid (to FETCH_OP at jump_target) or reset leaves HALTED.
- Not defined: HALTED does not exist, and 8'h00 is an ordinary one-byte instruction.

## Test plan
- Reset with RESET_PC=0 and ROM 0:B1 1:0A, instr_ready high:
  - instr_valid rises 2 cycles after the first fetch cycle.
  - Outputs: opcode=B1, imm=0A, has_imm=1, pc=00.
  - Then rom_address=02.
- ROM 2:82 3:44 4:9E, instr_ready low for 5 cycles:
  - Outputs held at opcode=82, imm=44, rom_address frozen at 04.
  - After ready rises, opcode=9E is fetched next.
- One-byte opcode 3C at 10, instr_ready high:
  - valid with has_imm=0, imm=00.
  - The next opcode address is 11, and the next valid appears 2 cycles after the handshake.
- jump_valid with target=40 while in FETCH_IMM for opcode at 20:
  - No instruction from 20 is delivered.
  - rom_address=40 the next cycle.
  - instr_pc=40 on the next valid.
- PC wrap: opcode 85 at FF, byte 77 at 00 → opcode=85, imm=77, pc=FF, next fetch at 01.
- With INSTR_FETCH_HALT_EN: opcode 00 at 05, accepted:
  - instr_valid stays 0 for 10 cycles and rom_address stays 06.
  - jump_valid with target=00 resumes fetch.
  - Without the macro, 00 is followed by a fetch at 06.
